// File: rtl/fmul_sched_pkg.sv
// Shared types and helpers for the fmul_sched multiply scheduler.
//   FP_W    : operand/result width (IEEE-754 single)
//   CNT_W   : width of the optional per-requester grant counters
//   ID_W    : requester id width (supports up to MAX_REQ requesters)
//   tag_t   : one tag-pipe stage {valid, id}
//   rr_pick : round-robin one-hot pick from a valid vector and a start pointer
package fmul_sched_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned MAX_REQ = 8;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // First set bit of valid at or above ptr, wrapping at n-1 back to 0.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [ID_W-1:0]    ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [ID_W-1:0]    idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % n);
            if ((k < n) && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fmul_sched_if.sv
// Requester and multiplier-side bus of the fmul_sched scheduler.
//   iReqValid/iReqA/iReqB : per-requester requests (operands packed 32 bits each)
//   oReqReady             : one-hot grant
//   oRspValid/oRspZ       : one-hot response strobe and shared result
//   oMulA/oMulB/iMulZ     : operand outputs to and result input from the multiplier
//   oBusy                 : any operation in flight
//   oGrantCnt             : per-requester grant counters (FMUL_SCHED_STATS_EN only)
// master: requesters + multiplier environment; slave: the scheduler.
interface fmul_sched_if #(
    parameter int unsigned NREQ = 4
);
    import fmul_sched_pkg::*;

    logic [NREQ-1:0]      iReqValid;
    logic [NREQ*FP_W-1:0] iReqA;
    logic [NREQ*FP_W-1:0] iReqB;
    logic [NREQ-1:0]      oReqReady;
    logic [NREQ-1:0]      oRspValid;
    logic [FP_W-1:0]      oRspZ;
    logic [FP_W-1:0]      oMulA;
    logic [FP_W-1:0]      oMulB;
    logic [FP_W-1:0]      iMulZ;
    logic                 oBusy;
`ifdef FMUL_SCHED_STATS_EN
    logic [NREQ*CNT_W-1:0] oGrantCnt;

    modport master (
        output iReqValid, iReqA, iReqB, iMulZ,
        input  oReqReady, oRspValid, oRspZ, oMulA, oMulB, oBusy, oGrantCnt
    );
    modport slave (
        input  iReqValid, iReqA, iReqB, iMulZ,
        output oReqReady, oRspValid, oRspZ, oMulA, oMulB, oBusy, oGrantCnt
    );
`else
    modport master (
        output iReqValid, iReqA, iReqB, iMulZ,
        input  oReqReady, oRspValid, oRspZ, oMulA, oMulB, oBusy
    );
    modport slave (
        input  iReqValid, iReqA, iReqB, iMulZ,
        output oReqReady, oRspValid, oRspZ, oMulA, oMulB, oBusy
    );
`endif

endinterface

// File: rtl/fmul_rr_arbiter.sv
// Round-robin arbiter for fmul_sched: owns the rotating pointer and produces
// a combinational one-hot grant.
//   clk, reset : clock, synchronous active-high reset
//   iValid     : per-requester valid
//   oGrant     : one-hot grant or zero; held at zero while reset is high
module fmul_rr_arbiter
    import fmul_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] iValid,
    output logic [NREQ-1:0] oGrant
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [NREQ-1:0] pick;

    // Grant selection and pointer advance past the granted index.
    always_comb begin
        pick     = '0;
        ptr_next = ptr;
        if (!reset) begin
            pick = NREQ'(rr_pick(MAX_REQ'(iValid), ptr, NREQ));
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                ptr_next = (i == NREQ - 1) ? '0 : ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    assign oGrant = pick;

endmodule

// File: rtl/fmul_sched.sv
// Shared-issue scheduler in front of one pipelined FP multiplier.
// Arbitrates NREQ requesters round-robin, registers the granted operands
// toward the multiplier and follows each issue with a {valid,id} tag so the
// result is steered back to its requester MUL_LAT+1 cycles after transfer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fmul_sched_if slave (requests, responses, multiplier side)
// Optional feature macro: FMUL_SCHED_STATS_EN adds saturating per-requester
// 16-bit grant counters on bus.oGrantCnt.
module fmul_sched
    import fmul_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    fmul_sched_if.slave bus
);

    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] xfer;
    logic            any_xfer;
    logic [FP_W-1:0] sel_a;
    logic [FP_W-1:0] sel_b;
    logic [ID_W-1:0] sel_id;
    logic            busy_next;

    tag_t            tags [MUL_LAT+1];
    logic [FP_W-1:0] mul_a;
    logic [FP_W-1:0] mul_b;
    logic [NREQ-1:0] rsp_valid;
    logic [FP_W-1:0] rsp_z;
    logic            busy;

    fmul_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .iValid (bus.iReqValid),
        .oGrant (grant)
    );

    assign xfer     = bus.iReqValid & grant;
    assign any_xfer = |xfer;

    // Operand mux from the one-hot transfer vector.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (xfer[i]) begin
                sel_a  = bus.iReqA[i*FP_W +: FP_W];
                sel_b  = bus.iReqB[i*FP_W +: FP_W];
                sel_id = ID_W'(i);
            end
        end
    end

    // Busy after the edge: the new stage-0 tag or any tag that shifts on.
    always_comb begin
        busy_next = any_xfer;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            busy_next = busy_next | tags[i].valid;
        end
    end

    // Operand registers, tag pipe and response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= '0;
            rsp_z     <= '0;
            busy      <= 1'b0;
            for (int unsigned i = 0; i <= MUL_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            mul_a   <= any_xfer ? sel_a : '0;
            mul_b   <= any_xfer ? sel_b : '0;
            tags[0] <= '{valid: any_xfer, id: sel_id};
            for (int unsigned i = 1; i <= MUL_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
            // The last tag stage lines up with the multiplier result on iMulZ.
            rsp_valid <= tags[MUL_LAT].valid ? (NREQ'(1) << tags[MUL_LAT].id) : '0;
            if (tags[MUL_LAT].valid) begin
                rsp_z <= bus.iMulZ;
            end
            busy <= busy_next;
        end
    end

    assign bus.oReqReady = grant;
    assign bus.oMulA     = mul_a;
    assign bus.oMulB     = mul_b;
    assign bus.oRspValid = rsp_valid;
    assign bus.oRspZ     = rsp_z;
    assign bus.oBusy     = busy;

`ifdef FMUL_SCHED_STATS_EN
    // Saturating grant counters, one per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (xfer[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign bus.oGrantCnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_fmul_sched.sv
// Testbench for fmul_sched: directed steps from the test plan followed by a
// randomized phase, all checked against a cycle-level reference model.
module tb_fmul_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned MUL_LAT = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fmul_sched_if #(.NREQ(NREQ)) bus ();

    fmul_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Exact single-precision product for normal operands whose significands
    // carry at most 8 bits, so no rounding is ever needed.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) return 32'd0;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {a[31] ^ b[31], 8'(e + 1), p[46:24]};
        return {a[31] ^ b[31], 8'(e), p[45:23]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'($urandom_range(100, 150)), r[6:0], 16'h0000};
    endfunction

    // Multiplier model: fixed MUL_LAT-cycle pipeline.
    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul_ref(bus.oMulA, bus.oMulB);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.iMulZ = mpipe[MUL_LAT-1];

    typedef struct {
        int unsigned due;
        int unsigned id;
        logic [31:0] z;
    } exp_t;

    int unsigned     checks   = 0;
    int unsigned     failures = 0;
    int unsigned     cyc      = 0;
    int unsigned     m_ptr    = 0;
    exp_t            expq [$];
    logic [31:0]     m_last_z = 32'd0;
    logic [NREQ-1:0] pend     = '0;
    logic [31:0]     pa [NREQ];
    logic [31:0]     pb [NREQ];
    logic [NREQ-1:0] obs_ready;
    logic [NREQ-1:0] obs_rv;
    logic [31:0]     obs_z;
    logic [31:0]     obs_mul_a;
    logic [31:0]     rsp_z_of [NREQ];
    int unsigned     rsp_count = 0;
    int unsigned     snap;
`ifdef FMUL_SCHED_STATS_EN
    logic [15:0]     m_cnt [NREQ];
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive requests, check grant, advance, check outputs.
    task automatic tick();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] erv;
        logic [31:0]     ez;
        logic [31:0]     ea;
        logic [31:0]     eb;
        int unsigned     gid;
        int unsigned     idx;
        logic            was_reset;
        exp_t            e;
        bus.iReqValid = pend;
        for (int i = 0; i < NREQ; i++) begin
            bus.iReqA[i*32 +: 32] = pa[i];
            bus.iReqB[i*32 +: 32] = pb[i];
        end
        #1;
        was_reset = reset;
        eg  = '0;
        gid = 0;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if ((eg == '0) && pend[idx]) begin
                    eg[idx] = 1'b1;
                    gid     = idx;
                end
            end
        end
        obs_ready = bus.oReqReady;
        chk("ready", 64'(bus.oReqReady), 64'(eg));
        ea = 32'd0;
        eb = 32'd0;
        if (eg != '0) begin
            ea = pa[gid];
            eb = pb[gid];
            expq.push_back('{cyc + MUL_LAT + 2, gid, fmul_ref(ea, eb)});
            m_ptr     = (gid + 1) % NREQ;
            pend[gid] = 1'b0;
`ifdef FMUL_SCHED_STATS_EN
            if (m_cnt[gid] != 16'hFFFF) m_cnt[gid] = m_cnt[gid] + 16'd1;
`endif
        end
        @(posedge clk);
        cyc++;
        #1;
        if (was_reset) begin
            expq.delete();
            m_ptr    = 0;
            m_last_z = 32'd0;
`ifdef FMUL_SCHED_STATS_EN
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 16'd0;
`endif
        end
        erv = '0;
        ez  = m_last_z;
        if ((expq.size() > 0) && (expq[0].due == cyc)) begin
            e = expq.pop_front();
            erv[e.id] = 1'b1;
            ez        = e.z;
            m_last_z  = e.z;
        end
        obs_rv    = bus.oRspValid;
        obs_z     = bus.oRspZ;
        obs_mul_a = bus.oMulA;
        chk("mul_a", 64'(bus.oMulA), 64'(ea));
        chk("mul_b", 64'(bus.oMulB), 64'(eb));
        chk("rsp_valid", 64'(bus.oRspValid), 64'(erv));
        chk("rsp_z", 64'(bus.oRspZ), 64'(ez));
        chk("busy", 64'(bus.oBusy), 64'(expq.size() > 0));
`ifdef FMUL_SCHED_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("grant_cnt", 64'(bus.oGrantCnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        if (bus.oRspValid != '0) begin
            rsp_count++;
            for (int i = 0; i < NREQ; i++) if (bus.oRspValid[i]) rsp_z_of[i] = bus.oRspZ;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        repeat (MUL_LAT + 5) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pa[i]       = 32'd0;
            pb[i]       = 32'd0;
            rsp_z_of[i] = 32'd0;
`ifdef FMUL_SCHED_STATS_EN
            m_cnt[i]    = 16'd0;
`endif
        end
        bus.iReqValid = '0;
        bus.iReqA     = '0;
        bus.iReqB     = '0;

        // Reset values.
        do_reset(3);
        chk("reset_rsp_z", 64'(obs_z), 64'd0);
        chk("reset_busy", 64'(bus.oBusy), 64'd0);

        // Single request: 12.5 * 8.5 = 106.25 four cycles after transfer.
        pa[0] = 32'h41480000; pb[0] = 32'h41080000; pend[0] = 1'b1;
        tick();
        chk("t1_ready", 64'(obs_ready), 64'h1);
        repeat (3) tick();
        chk("t1_no_early_rsp", 64'(obs_rv), 64'h0);
        tick();
        chk("t1_rsp_valid", 64'(obs_rv), 64'h1);
        chk("t1_rsp_z", 64'(obs_z), 64'h42D48000);
        drain();

        // All four held from reset release: grants 0,1,2,3 in order.
        do_reset(1);
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = rnd_fp(); pb[i] = rnd_fp(); pend[i] = 1'b1;
        end
        pa[1] = 32'hC2480000; pb[1] = 32'h41080000;
        for (int i = 0; i < NREQ; i++) begin
            tick();
            chk("t2_grant_order", 64'(obs_ready), 64'(1) << i);
        end
        drain();
        chk("t2_req1_z", 64'(rsp_z_of[1]), 64'hC3D48000);

        // Wrap-around from ptr=3.
        do_reset(1);
        pa[2] = rnd_fp(); pb[2] = rnd_fp(); pend[2] = 1'b1;
        tick();
        chk("t3_first", 64'(obs_ready), 64'h4);
        pend[0] = 1'b1; pend[3] = 1'b1;
        tick();
        chk("t3_wrap_req3", 64'(obs_ready), 64'h8);
        tick();
        chk("t3_wrap_req0", 64'(obs_ready), 64'h1);
        pend[0] = 1'b1; pend[1] = 1'b1;
        tick();
        chk("t3_ptr1", 64'(obs_ready), 64'h2);
        drain();

        // Reset mid-flight discards both results.
        pend[0] = 1'b1; pend[1] = 1'b1;
        tick();
        tick();
        do_reset(1);
        snap = rsp_count;
        repeat (10) tick();
        chk("t4_no_rsp", 64'(rsp_count - snap), 64'd0);
        chk("t4_busy", 64'(bus.oBusy), 64'd0);
        chk("t4_rsp_z", 64'(bus.oRspZ), 64'd0);

        // Idle slot between requests.
        pa[2] = rnd_fp(); pb[2] = rnd_fp(); pend[2] = 1'b1;
        tick();
        tick();
        chk("t5_idle_mul_a", 64'(obs_mul_a), 64'd0);
        pa[3] = rnd_fp(); pb[3] = rnd_fp(); pend[3] = 1'b1;
        tick();
        drain();

        // Randomized traffic with drops and a mid-run reset.
        for (int n = 0; n < 400; n++) begin
            reset = (n == 200);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 40)) begin
                    pa[i] = rnd_fp(); pb[i] = rnd_fp(); pend[i] = 1'b1;
                end else if (pend[i] && ($urandom_range(0, 99) < 5)) begin
                    pend[i] = 1'b0;
                end
            end
            tick();
        end
        reset = 1'b0;
        pend  = '0;
        drain();

`ifdef FMUL_SCHED_STATS_EN
        // Grant counters: count and saturation.
        do_reset(1);
        for (int n = 0; n < 5; n++) begin
            pa[1] = rnd_fp(); pb[1] = rnd_fp(); pend[1] = 1'b1;
            tick();
            tick();
        end
        chk("cnt_req1", 64'(bus.oGrantCnt[31:16]), 64'd5);
        chk("cnt_req0", 64'(bus.oGrantCnt[15:0]), 64'd0);
        chk("cnt_req2", 64'(bus.oGrantCnt[47:32]), 64'd0);
        chk("cnt_req3", 64'(bus.oGrantCnt[63:48]), 64'd0);
        force dut.g_cnt[1].cnt_q = 16'hFFFE;
        #1;
        release dut.g_cnt[1].cnt_q;
        m_cnt[1] = 16'hFFFE;
        for (int n = 0; n < 3; n++) begin
            pend[1] = 1'b1;
            tick();
            tick();
        end
        chk("cnt_sat", 64'(bus.oGrantCnt[31:16]), 64'hFFFF);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
